// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES encryption and decryption round controllers:
// state encoding and round-count constants.
package aes_ctrl_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int ROUND_W    = 4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_EXPAND = 4'd1,
    S_ADD0   = 4'd2,
    S_SUB    = 4'd3,
    S_ROW    = 4'd4,
    S_COL    = 4'd5,
    S_ADD    = 4'd6,
    S_OUT    = 4'd7,
    S_DONE   = 4'd8
  } state_e;

endpackage

// File: rtl/aes_round_counter.sv
// Round-key index counter: clears to zero, saturating increment up to
// NUM_ROUNDS, and flags the final round.
module aes_round_counter
  import aes_ctrl_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_zero_i,
  input  logic               incr_i,
  output logic [ROUND_W-1:0] round_idx_o,
  output logic               eq_final_o
);

  logic [ROUND_W-1:0] round_q;
  logic [ROUND_W-1:0] round_d;

  assign eq_final_o  = (round_q == ROUND_W'(NUM_ROUNDS));
  assign round_idx_o = round_q;

  // NOTE: round_d gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    round_d = round_q;
    if (load_zero_i) begin
      round_d = '0;
    end else if (incr_i && !eq_final_o) begin
      round_d = round_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, matching hardware regardless of block ordering.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/aes_enc_control.sv
// AES-128 encryption sequencer: drives key expansion, then ten rounds of
// SubBytes/ShiftRows/MixColumns/AddRoundKey enables on the datapath.
module aes_enc_control
  import aes_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               encrypt,
  input  logic               expand_done,
  output logic               init,
  output logic               key_init,
  output logic               key_step,
  output logic               store_key,
  output logic               en_add_key_out,
  output logic               en_reg_sub_out,
  output logic               en_reg_row_out,
  output logic               en_reg_col_out,
  output logic               is_final_round,
  output logic [ROUND_W-1:0] round_idx,
  output logic               en_Dout,
  output logic               done,
  output logic               busy
);

  state_e state_q;
  state_e state_d;
  logic   eq_final;
  logic   start;

  // Start is decoded combinationally so the plaintext and key loads happen in
  // the same cycle encrypt is seen.
  assign start    = ((state_q == S_IDLE) || (state_q == S_DONE)) && encrypt;
  assign init     = start;
  assign key_init = start;
  assign key_step = (state_q == S_EXPAND) && !expand_done;

  aes_round_counter u_round_counter (
    .clock_i     (clock),
    .reset_i     (reset),
    .load_zero_i ((state_q == S_EXPAND) && expand_done),
    .incr_i      ((state_q == S_ADD0) || (state_q == S_ADD)),
    .round_idx_o (round_idx),
    .eq_final_o  (eq_final)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (encrypt) state_d = S_EXPAND;
      S_EXPAND:       if (expand_done) state_d = S_ADD0;
      S_ADD0:         state_d = S_SUB;
      S_SUB:          state_d = S_ROW;
      S_ROW:          state_d = eq_final ? S_ADD : S_COL;
      S_COL:          state_d = S_ADD;
      S_ADD:          state_d = eq_final ? S_OUT : S_SUB;
      S_OUT:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with
  // the state they belong to without a decode path after the flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      store_key      <= 1'b0;
      en_add_key_out <= 1'b0;
      en_reg_sub_out <= 1'b0;
      en_reg_row_out <= 1'b0;
      en_reg_col_out <= 1'b0;
      is_final_round <= 1'b0;
      en_Dout        <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      store_key      <= (state_d == S_EXPAND);
      en_add_key_out <= (state_d == S_ADD0) || (state_d == S_ADD);
      en_reg_sub_out <= (state_d == S_SUB);
      en_reg_row_out <= (state_d == S_ROW);
      en_reg_col_out <= (state_d == S_COL);
      // The last-round S_ADD is the only one entered straight from S_ROW.
      is_final_round <= (state_d == S_ADD) && (state_q == S_ROW) && eq_final;
      en_Dout        <= (state_d == S_OUT);
      done           <= (state_d == S_DONE);
      busy           <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

endmodule

// File: tb/tb_aes_enc_control.sv
// Directed self-checking bench for aes_enc_control: full operations with
// different expansion delays, held start, restart from done and mid-run reset.
module tb_aes_enc_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       encrypt;
  logic       expand_done;
  logic       init, key_init, key_step, store_key;
  logic       en_add_key_out, en_reg_sub_out, en_reg_row_out, en_reg_col_out;
  logic       is_final_round, en_Dout, done, busy;
  logic [3:0] round_idx;
  logic [11:0] all_out;

  int checks   = 0;
  int failures = 0;

  aes_enc_control dut (
    .clock          (clock),
    .reset          (reset),
    .encrypt        (encrypt),
    .expand_done    (expand_done),
    .init           (init),
    .key_init       (key_init),
    .key_step       (key_step),
    .store_key      (store_key),
    .en_add_key_out (en_add_key_out),
    .en_reg_sub_out (en_reg_sub_out),
    .en_reg_row_out (en_reg_row_out),
    .en_reg_col_out (en_reg_col_out),
    .is_final_round (is_final_round),
    .round_idx      (round_idx),
    .en_Dout        (en_Dout),
    .done           (done),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  assign all_out = {init, key_init, key_step, store_key, en_add_key_out,
                    en_reg_sub_out, en_reg_row_out, en_reg_col_out,
                    is_final_round, en_Dout, done, busy};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic expect_quiet(input string name);
    checks++;
    if (all_out !== 12'h000 || round_idx !== 4'd0) begin
      failures++;
      $display("FAIL %s: got outputs=%b round_idx=%0d expected outputs=0 round_idx=0",
               name, all_out, round_idx);
    end
  endtask

  // Reset with encrypt high on the same edges, then idle with stray inputs.
  task automatic test_reset();
    reset = 1'b1; encrypt = 1'b1; expand_done = 1'b0;
    tick();
    tick();
    reset = 1'b0; encrypt = 1'b0;
    @(negedge clock);
    expect_quiet("reset_state");
    tick();
    expand_done = 1'b1;
    @(negedge clock);
    expect_quiet("idle_ignores_expand_done");
    tick();
    @(negedge clock);
    expect_quiet("idle_stays_idle");
    tick();
  endtask

  // One full operation starting in S_IDLE or S_DONE. e = first S_EXPAND cycle
  // with expand_done high (0 means tied high). hold keeps encrypt asserted.
  task automatic run_op(input string tag, input int e, input bit hold);
    int e_eff = (e < 1) ? 1 : e;
    int done_cyc = -1;
    int n_add = 0, n_sub = 0, n_row = 0, n_col = 0, n_dout = 0, n_fin = 0;
    int n_step = 0, n_store = 0, exp_round = 0, seq_err = 0, bad = 0;
    encrypt = 1'b1;
    expand_done = (e <= 0);
    @(negedge clock);
    expect_int({tag, "_start_init_keyinit_busy"}, int'({init, key_init, busy}), 3'b110);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      encrypt = hold;
      expand_done = (cyc >= e);
      @(negedge clock);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (en_add_key_out) begin
        if (round_idx !== exp_round[3:0]) seq_err++;
        exp_round++;
        n_add++;
      end
      if (en_reg_sub_out) n_sub++;
      if (en_reg_row_out) n_row++;
      if (en_reg_col_out) begin
        n_col++;
        if (round_idx == 4'd10) bad++;
      end
      if (is_final_round) begin
        n_fin++;
        if (!(en_add_key_out && round_idx == 4'd10)) bad++;
      end
      if (en_Dout) n_dout++;
      if (key_step) n_step++;
      if (store_key) n_store++;
      if (init || key_init || !busy) bad++;
    end
    expect_int({tag, "_done_cycle"}, done_cyc, e_eff + 42);
    expect_int({tag, "_add_key_pulses"}, n_add, 11);
    expect_int({tag, "_sub_pulses"}, n_sub, 10);
    expect_int({tag, "_row_pulses"}, n_row, 10);
    expect_int({tag, "_col_pulses"}, n_col, 9);
    expect_int({tag, "_dout_pulses"}, n_dout, 1);
    expect_int({tag, "_final_round_pulses"}, n_fin, 1);
    expect_int({tag, "_key_step_cycles"}, n_step, e_eff - 1);
    expect_int({tag, "_store_key_cycles"}, n_store, e_eff);
    expect_int({tag, "_round_idx_sequence_errors"}, seq_err, 0);
    expect_int({tag, "_protocol_violations"}, bad, 0);
    expect_int({tag, "_round_idx_at_done"}, int'(round_idx), 10);
    expect_int({tag, "_done_cycle_init_keyinit_busy"}, int'({init, key_init, busy}),
               hold ? 3'b110 : 3'b000);
    tick();
    encrypt = 1'b0;
    @(negedge clock);
    if (hold) begin
      expect_int({tag, "_restart_busy_done"}, int'({busy, done}), 2'b10);
    end else begin
      expect_int({tag, "_done_held_busy_done"}, int'({busy, done}), 2'b01);
    end
    tick();
  endtask

  task automatic test_basic();
    run_op("basic", 0, 1'b0);
  endtask

  task automatic test_delayed_expand();
    run_op("delayed", 12, 1'b0);
  endtask

  task automatic test_hold_encrypt();
    run_op("hold", 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int hit = -1;
    reset = 1'b1; encrypt = 1'b0; expand_done = 1'b1;
    tick();
    reset = 1'b0;
    encrypt = 1'b1;
    @(negedge clock);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      encrypt = 1'b0;
      @(negedge clock);
      if (en_reg_col_out && round_idx == 4'd5) begin
        hit = cyc;
        break;
      end
    end
    expect_int("round5_col_cycle", hit, 21);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    expect_quiet("reset_mid_round");
    tick();

    // Reset in the middle of key expansion.
    expand_done = 1'b0;
    encrypt = 1'b1;
    tick();
    encrypt = 1'b0;
    tick();
    tick();
    @(negedge clock);
    expect_int("expansion_store_key_busy", int'({store_key, busy, key_step}), 3'b111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expand_done = 1'b1;
    @(negedge clock);
    expect_quiet("reset_mid_expansion");
    tick();
    @(negedge clock);
    expect_quiet("idle_after_expansion_reset");
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_expand();
    test_hold_encrypt();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
